// File: rtl/tk_pkg.sv
// Shared field limits, field selector encoding and the modular step helper
// used by the timekeeper core.
package tk_pkg;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  typedef enum logic [1:0] {
    FIELD_SEC  = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_HOUR = 2'd2,
    FIELD_NONE = 2'd3
  } field_e;

  // One step up or down, wrapping within 0..max with no carry out.
  function automatic logic [5:0] wrap_step(input logic [5:0] val,
                                           input logic [5:0] max,
                                           input logic       up);
    if (up) return (val == max) ? 6'd0 : val + 6'd1;
    else    return (val == 6'd0) ? max : val - 6'd1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter; tick marks the cycle in which it wraps.
// clr holds the count at zero so the next tick is a full period away.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking <= so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr)        cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST) && !clr && !rst;

endmodule

// File: rtl/timekeeper_core.sv
// 24 h time-of-day counter with prescaled second ticks, a level-gated edit
// mode driven by inc/dec edges, and a combinational 12 h display encoder.
module timekeeper_core
  import tk_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SPEEDUP    = 1,
  parameter int RESET_HOUR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edit_en,
  input  logic [1:0] field_sel,
  input  logic       inc,
  input  logic       dec,
  input  logic       mode_12h,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour_disp,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_carry
);

  localparam int DIV = CLK_HZ / SPEEDUP;

  logic       tick;
  logic       inc_q, dec_q;
  logic       inc_rise, dec_rise;
  logic [4:0] hour;
  logic [5:0] sec_d, min_d;
  logic [4:0] hour_d;
  logic       pulse_d, carry_d;
  field_e     field;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (edit_en),
    .tick (tick)
  );

  assign field    = field_e'(field_sel);
  assign inc_rise = inc & ~inc_q;
  assign dec_rise = dec & ~dec_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sec_d   = sec;
    min_d   = min;
    hour_d  = hour;
    pulse_d = 1'b0;
    carry_d = 1'b0;
    if (edit_en) begin
      // Simultaneous inc and dec edges cancel out.
      if (inc_rise ^ dec_rise) begin
        case (field)
          FIELD_SEC:  sec_d  = wrap_step(sec, SEC_MAX, inc_rise);
          FIELD_MIN:  min_d  = wrap_step(min, MIN_MAX, inc_rise);
          FIELD_HOUR: hour_d = 5'(wrap_step({1'b0, hour}, {1'b0, HOUR_MAX}, inc_rise));
          default:    ;
        endcase
      end
    end else if (tick) begin
      pulse_d = 1'b1;
      if (sec == SEC_MAX) begin
        sec_d = 6'd0;
        if (min == MIN_MAX) begin
          min_d = 6'd0;
          if (hour == HOUR_MAX) begin
            hour_d  = 5'd0;
            carry_d = 1'b1;
          end else begin
            hour_d = hour + 5'd1;
          end
        end else begin
          min_d = min + 6'd1;
        end
      end else begin
        sec_d = sec + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec       <= 6'd0;
      min       <= 6'd0;
      hour      <= 5'(RESET_HOUR);
      sec_pulse <= 1'b0;
      day_carry <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      sec       <= sec_d;
      min       <= min_d;
      hour      <= hour_d;
      sec_pulse <= pulse_d;
      day_carry <= carry_d;
      inc_q     <= inc;
      dec_q     <= dec;
    end
  end

  always_comb begin
    hour_disp = hour;
    if (mode_12h) begin
      if (hour == 5'd0)      hour_disp = 5'd12;
      else if (hour > 5'd12) hour_disp = hour - 5'd12;
    end
  end

  assign pm = (hour >= 5'd12);

endmodule

// File: tb/tb_timekeeper_core.sv
// Directed bench for timekeeper_core at CLK_HZ=4 (four cycles per second);
// inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_timekeeper_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       edit_en = 1'b0;
  logic [1:0] field_sel = 2'd0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic       mode_12h = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hour_disp;
  logic       pm, sec_pulse, day_carry;

  int total = 0;
  int bad   = 0;

  timekeeper_core #(.CLK_HZ(4), .SPEEDUP(1), .RESET_HOUR(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .edit_en   (edit_en),
    .field_sel (field_sel),
    .inc       (inc),
    .dec       (dec),
    .mode_12h  (mode_12h),
    .sec       (sec),
    .min       (min),
    .hour_disp (hour_disp),
    .pm        (pm),
    .sec_pulse (sec_pulse),
    .day_carry (day_carry)
  );

  always #5 clk = ~clk;

  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic edit);
    rst = 1'b1; edit_en = edit; inc = 1'b0; dec = 1'b0; field_sel = 2'd0; mode_12h = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic edit_pulse(input logic [1:0] fld, input logic up, input int count);
    field_sel = fld;
    for (int i = 0; i < count; i++) begin
      if (up) inc = 1'b1; else dec = 1'b1;
      cycle();
      inc = 1'b0; dec = 1'b0;
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(2);
    total++; if (sec !== 6'd0) begin bad++; $display("FAIL reset_sec got=%0d exp=0", sec); end
    total++; if (min !== 6'd0) begin bad++; $display("FAIL reset_min got=%0d exp=0", min); end
    total++; if (hour_disp !== 5'd0) begin bad++; $display("FAIL reset_hour got=%0d exp=0", hour_disp); end
    total++; if (pm !== 1'b0) begin bad++; $display("FAIL reset_pm got=%0b exp=0", pm); end
    total++; if (sec_pulse !== 1'b0 || day_carry !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got=%0b%0b exp=00", sec_pulse, day_carry);
    end
  endtask

  task automatic test_count();
    do_reset(1'b0);
    for (int c = 1; c <= 8; c++) begin
      cycle();
      total++; if (sec_pulse !== (c % 4 == 0)) begin
        bad++; $display("FAIL count_pulse cyc=%0d got=%0b exp=%0b", c, sec_pulse, (c % 4 == 0));
      end
    end
    total++; if (sec !== 6'd2) begin bad++; $display("FAIL count_sec got=%0d exp=2", sec); end
  endtask

  task automatic test_ignore_when_running();
    do_reset(1'b0);
    field_sel = 2'd0; inc = 1'b1;
    cycle(2);
    inc = 1'b0;
    total++; if (sec !== 6'd0) begin bad++; $display("FAIL run_inc_ignored got=%0d exp=0", sec); end
  endtask

  task automatic test_day_carry();
    do_reset(1'b1);
    edit_pulse(2'd0, 1'b0, 1);
    edit_pulse(2'd1, 1'b0, 1);
    edit_pulse(2'd2, 1'b0, 1);
    total++; if (sec !== 6'd59 || min !== 6'd59 || hour_disp !== 5'd23) begin
      bad++; $display("FAIL preset got=%0d:%0d:%0d exp=23:59:59", hour_disp, min, sec);
    end
    edit_en = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      cycle();
      total++; if (day_carry !== (c == 4)) begin
        bad++; $display("FAIL day_carry cyc=%0d got=%0b exp=%0b", c, day_carry, (c == 4));
      end
    end
    total++; if (sec !== 6'd0 || min !== 6'd0 || hour_disp !== 5'd0) begin
      bad++; $display("FAIL midnight got=%0d:%0d:%0d exp=0:0:0", hour_disp, min, sec);
    end
  endtask

  task automatic test_edit_wrap();
    do_reset(1'b1);
    edit_pulse(2'd1, 1'b0, 1);
    total++; if (min !== 6'd59 || hour_disp !== 5'd0) begin
      bad++; $display("FAIL min_dec_wrap got=%0d:%0d exp=0:59", hour_disp, min);
    end
    inc = 1'b1;
    cycle(10);
    inc = 1'b0;
    total++; if (min !== 6'd0) begin bad++; $display("FAIL min_hold_inc got=%0d exp=0", min); end
    edit_pulse(2'd2, 1'b0, 1);
    total++; if (hour_disp !== 5'd23) begin bad++; $display("FAIL hour_dec_wrap got=%0d exp=23", hour_disp); end
    edit_pulse(2'd2, 1'b1, 1);
    total++; if (hour_disp !== 5'd0) begin bad++; $display("FAIL hour_inc_wrap got=%0d exp=0", hour_disp); end
    edit_pulse(2'd3, 1'b1, 1);
    total++; if (sec !== 6'd0 || min !== 6'd0 || hour_disp !== 5'd0) begin
      bad++; $display("FAIL field_none got=%0d:%0d:%0d exp=0:0:0", hour_disp, min, sec);
    end
    cycle(6);
    total++; if (sec_pulse !== 1'b0 || sec !== 6'd0) begin
      bad++; $display("FAIL edit_frozen got pulse=%0b sec=%0d exp pulse=0 sec=0", sec_pulse, sec);
    end
  endtask

  task automatic test_both_and_exit();
    do_reset(1'b1);
    edit_pulse(2'd0, 1'b1, 30);
    total++; if (sec !== 6'd30) begin bad++; $display("FAIL sec_preset got=%0d exp=30", sec); end
    inc = 1'b1; dec = 1'b1;
    cycle();
    inc = 1'b0; dec = 1'b0;
    cycle();
    total++; if (sec !== 6'd30) begin bad++; $display("FAIL inc_dec_cancel got=%0d exp=30", sec); end
    inc = 1'b1;
    cycle();
    edit_en = 1'b0; inc = 1'b0;
    total++; if (sec !== 6'd31) begin bad++; $display("FAIL exit_step got=%0d exp=31", sec); end
    cycle(3);
    total++; if (sec !== 6'd31 || sec_pulse !== 1'b0) begin
      bad++; $display("FAIL exit_early got sec=%0d pulse=%0b exp sec=31 pulse=0", sec, sec_pulse);
    end
    cycle();
    total++; if (sec !== 6'd32 || sec_pulse !== 1'b1) begin
      bad++; $display("FAIL exit_tick got sec=%0d pulse=%0b exp sec=32 pulse=1", sec, sec_pulse);
    end
  endtask

  task automatic test_12h();
    do_reset(1'b1);
    mode_12h = 1'b1;
    #1;
    total++; if (hour_disp !== 5'd12 || pm !== 1'b0) begin
      bad++; $display("FAIL h12_0 got=%0d pm=%0b exp=12 pm=0", hour_disp, pm);
    end
    edit_pulse(2'd2, 1'b1, 12);
    total++; if (hour_disp !== 5'd12 || pm !== 1'b1) begin
      bad++; $display("FAIL h12_12 got=%0d pm=%0b exp=12 pm=1", hour_disp, pm);
    end
    edit_pulse(2'd2, 1'b1, 1);
    total++; if (hour_disp !== 5'd1 || pm !== 1'b1) begin
      bad++; $display("FAIL h12_13 got=%0d pm=%0b exp=1 pm=1", hour_disp, pm);
    end
    mode_12h = 1'b0;
    #1;
    total++; if (hour_disp !== 5'd13 || pm !== 1'b1) begin
      bad++; $display("FAIL h24_13 got=%0d pm=%0b exp=13 pm=1", hour_disp, pm);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    edit_pulse(2'd0, 1'b1, 30);
    edit_pulse(2'd1, 1'b1, 20);
    edit_pulse(2'd2, 1'b1, 10);
    edit_en = 1'b0;
    cycle(2);
    total++; if (sec !== 6'd30 || min !== 6'd20 || hour_disp !== 5'd10) begin
      bad++; $display("FAIL pre_reset got=%0d:%0d:%0d exp=10:20:30", hour_disp, min, sec);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    total++; if (sec !== 6'd0 || min !== 6'd0 || hour_disp !== 5'd0 || sec_pulse !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%0d:%0d:%0d pulse=%0b exp=0:0:0 pulse=0",
                      hour_disp, min, sec, sec_pulse);
    end
    for (int c = 1; c <= 4; c++) begin
      cycle();
      total++; if (sec_pulse !== (c == 4)) begin
        bad++; $display("FAIL post_reset_tick cyc=%0d got=%0b exp=%0b", c, sec_pulse, (c == 4));
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_count();
    test_ignore_when_running();
    test_day_carry();
    test_edit_wrap();
    test_both_and_exit();
    test_12h();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
